// File: rtl/btb_update_queue_pkg.sv
// -----------------------------------------------------------------------------
// btb_update_queue_pkg
//
// Shared definitions for the BTB update queue:
//   XLEN            - width of source/destination PCs
//   BTB_UPDQ_DEPTH  - default number of queued updates
//   BTB_UPDATE      - one buffered update {source_pc, dest_pc}
// -----------------------------------------------------------------------------
package btb_update_queue_pkg;

  localparam int XLEN           = 32;
  localparam int BTB_UPDQ_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] source_pc;
    logic [XLEN-1:0] dest_pc;
  } BTB_UPDATE;

endpackage : btb_update_queue_pkg

// File: rtl/btb_update_queue.sv
// -----------------------------------------------------------------------------
// btb_update_queue
//
// Buffers resolved taken-branch updates and drains them one per cycle into the
// BTB's single write port. A circular buffer of DEPTH entries with head/tail
// pointers and an occupancy count.
//
// Ports:
//   clock                in   system clock, rising edge
//   reset                in   asynchronous, active-low; clears the queue
//   in_valid             in   producer presents an update
//   in_ready             out  queue accepts the update this cycle
//   in_source_pc         in   branch PC
//   in_dest_pc           in   resolved target PC
//   hold                 in   suppress draining this cycle
//   btb_write_enable     out  head entry is written into the BTB at this edge
//   btb_write_source_pc  out  head entry source PC (0 when empty)
//   btb_write_dest_pc    out  head entry target PC (0 when empty)
//   count                out  occupied entries
//
// Handshake: an update transfers on a rising edge where in_valid && in_ready
// are both high. While in_valid is high and in_ready low, the producer keeps
// in_source_pc/in_dest_pc stable; it may drop in_valid without a transfer.
// The BTB side has no ready: btb_write_enable high always consumes the head.
//
// Optional feature (macro BTB_UPDQ_COALESCE_EN): an incoming update whose
// source PC matches the newest queued entry overwrites that entry's target
// instead of taking a new slot, and is accepted even when the queue is full.
// -----------------------------------------------------------------------------
module btb_update_queue
  import btb_update_queue_pkg::*;
#(
  parameter int DEPTH = BTB_UPDQ_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [XLEN-1:0]              in_source_pc,
  input  logic [XLEN-1:0]              in_dest_pc,
  input  logic                         hold,
  output logic                         btb_write_enable,
  output logic [XLEN-1:0]              btb_write_source_pc,
  output logic [XLEN-1:0]              btb_write_dest_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  BTB_UPDATE       mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count_q;
  // Held low through reset and set on the first edge after release, so the
  // producer sees in_ready=0 for the whole reset interval.
  logic            ready_armed;

  // ---------------------------------------------------------------------------
  // Status and handshake
  // ---------------------------------------------------------------------------
  logic empty;
  logic full;
  logic accept;
  logic enq;
  logic deq;
  logic merge;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);

  assign btb_write_enable = !empty && !hold;
  assign deq              = btb_write_enable;

  // Head is shown even while hold is high; forced to zero when nothing is
  // queued so stale storage never reaches the BTB pins.
  assign btb_write_source_pc = empty ? '0 : mem[head].source_pc;
  assign btb_write_dest_pc   = empty ? '0 : mem[head].dest_pc;

`ifdef BTB_UPDQ_COALESCE_EN
  logic [PW-1:0] newest;
  logic          merge_hit;

  assign newest = tail - PW'(1);

  // If the newest entry is also the head leaving this cycle, overwriting it
  // would lose the new target, so that case falls back to a normal enqueue.
  assign merge_hit = !empty
                   && (mem[newest].source_pc == in_source_pc)
                   && !((count_q == CW'(1)) && btb_write_enable);

  assign in_ready = ready_armed && (!full || merge_hit);
  assign merge    = in_valid && in_ready && merge_hit;
`else
  assign in_ready = ready_armed && !full;
  assign merge    = 1'b0;
`endif

  assign accept = in_valid && in_ready;
  assign enq    = accept && !merge;

  assign count = count_q;

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head        <= '0;
      tail        <= '0;
      count_q     <= '0;
      ready_armed <= 1'b0;
    end else begin
      ready_armed <= 1'b1;
      if (enq) begin
        tail <= tail + PW'(1);
      end
      if (deq) begin
        head <= head + PW'(1);
      end
      // Simultaneous enqueue and dequeue leaves the count unchanged.
      case ({enq, deq})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage (data only; validity is tracked by count/head/tail)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (enq) begin
      mem[tail] <= '{source_pc: in_source_pc, dest_pc: in_dest_pc};
    end
`ifdef BTB_UPDQ_COALESCE_EN
    if (merge) begin
      mem[newest].dest_pc <= in_dest_pc;
    end
`endif
  end

endmodule : btb_update_queue

// File: tb/tb_btb_update_queue.sv
// -----------------------------------------------------------------------------
// tb_btb_update_queue
//
// Self-checking bench for btb_update_queue. The reference model is a queue of
// {source_pc, dest_pc} updates; expected outputs each cycle come from the
// queue contents and the hold input. Observed BTB writes are logged for
// order/once-only checks. Follows BTB_UPDQ_COALESCE_EN if defined.
// -----------------------------------------------------------------------------
module tb_btb_update_queue;
  import btb_update_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int W     = 2*XLEN;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_source_pc = '0;
  logic [XLEN-1:0] in_dest_pc = '0;
  logic            hold = 1'b0;
  logic            btb_write_enable;
  logic [XLEN-1:0] btb_write_source_pc;
  logic [XLEN-1:0] btb_write_dest_pc;
  logic [CW-1:0]   count;

  always #5 clock = ~clock;

  btb_update_queue #(.DEPTH(DEPTH)) dut (
    .clock               (clock),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_source_pc        (in_source_pc),
    .in_dest_pc          (in_dest_pc),
    .hold                (hold),
    .btb_write_enable    (btb_write_enable),
    .btb_write_source_pc (btb_write_source_pc),
    .btb_write_dest_pc   (btb_write_dest_pc),
    .count               (count)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];   // reference queue contents, oldest first
  logic [W-1:0] obs_log[$]; // every BTB write seen on the pins
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check the outputs
  // against the model, then advance the model at the rising edge.
  task automatic step(input logic v, input logic [XLEN-1:0] s, input logic [XLEN-1:0] d,
                      input logic h, output logic taken);
    logic [W-1:0]    e;
    logic            exp_en;
    logic            exp_ready;
    logic            hit;
    logic [XLEN-1:0] exp_src;
    logic [XLEN-1:0] exp_dst;
    @(negedge clock);
    in_valid = v; in_source_pc = s; in_dest_pc = d; hold = h;
    #1;
    exp_en  = (exp_q.size() != 0) && !h;
    exp_src = '0;
    exp_dst = '0;
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      exp_src = e[W-1:XLEN];
      exp_dst = e[XLEN-1:0];
    end
    hit = 1'b0;
`ifdef BTB_UPDQ_COALESCE_EN
    if (exp_q.size() != 0) begin
      e = exp_q[exp_q.size()-1];
      hit = (e[W-1:XLEN] == s) && !(exp_q.size() == 1 && exp_en);
    end
`endif
    exp_ready = (exp_q.size() != DEPTH) || hit;
    chk("count",    W'(count),               W'(exp_q.size()));
    chk("enable",   W'(btb_write_enable),    W'(exp_en));
    chk("src_pc",   W'(btb_write_source_pc), W'(exp_src));
    chk("dst_pc",   W'(btb_write_dest_pc),   W'(exp_dst));
    chk("in_ready", W'(in_ready),            W'(exp_ready));
    if (btb_write_enable === 1'b1) obs_log.push_back({btb_write_source_pc, btb_write_dest_pc});
    @(posedge clock);
    taken = v && exp_ready;
    if (exp_en) void'(exp_q.pop_front());
    if (taken) begin
      if (hit) begin
        e = exp_q[exp_q.size()-1];
        exp_q[exp_q.size()-1] = {e[W-1:XLEN], d};
      end else begin
        exp_q.push_back({s, d});
      end
    end
  endtask

  // Keep offering one update (stable) until it is taken or the budget expires.
  task automatic offer(input logic [XLEN-1:0] s, input logic [XLEN-1:0] d, input logic h,
                       input int budget);
    logic taken;
    taken = 1'b0;
    for (int i = 0; i < budget && !taken; i++) step(1'b1, s, d, h, taken);
    chk("offer_taken", W'(taken), W'(1'b1));
  endtask

  task automatic idle(input int n, input logic h);
    logic taken;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, h, taken);
  endtask

  // Assert reset away from the clock edge, check the asynchronous clear,
  // then release on a falling edge.
  task automatic apply_reset();
    @(negedge clock);
    #2;
    reset = 1'b0; in_valid = 1'b0; hold = 1'b0;
    #1;
    chk("rst_count",  W'(count),            W'(0));
    chk("rst_enable", W'(btb_write_enable), W'(0));
    chk("rst_ready",  W'(in_ready),         W'(0));
    chk("rst_src",    W'(btb_write_source_pc), W'(0));
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_hold_ready",  W'(in_ready),         W'(0));
    chk("rst_hold_enable", W'(btb_write_enable), W'(0));
    @(negedge clock);
    reset = 1'b1;
  endtask

  function automatic int log_count(input logic [W-1:0] entry);
    int n = 0;
    foreach (obs_log[i]) if (obs_log[i] == entry) n++;
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Directed and random stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic            taken;
    logic            pend;
    logic            h;
    logic [XLEN-1:0] rs;
    logic [XLEN-1:0] rd;
    int              log_base;

    // Power-on reset
    #1;
    chk("por_count",  W'(count),            W'(0));
    chk("por_enable", W'(btb_write_enable), W'(0));
    chk("por_ready",  W'(in_ready),         W'(0));
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Single update, then drain
    step(1'b1, 32'h100, 32'h200, 1'b0, taken);
    chk("single_taken", W'(taken), W'(1'b1));
    idle(2, 1'b0);
    chk("single_write", W'(log_count({32'h100, 32'h200})), W'(1));

    // Fill under hold, fifth is back-pressured, release hold
    for (int i = 0; i < 4; i++) offer(32'h400 + 32'(i*4), 32'h800 + 32'(i), 1'b1, 2);
    step(1'b1, 32'h4f0, 32'h8f0, 1'b1, taken);
    chk("fifth_refused", W'(taken), W'(1'b0));
    offer(32'h4f0, 32'h8f0, 1'b0, 3);
    idle(DEPTH + 2, 1'b0);

    // Continuous traffic with wrap-around
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h2000 + 32'(i*4), 32'h3000 + 32'(i*8), 1'b0, taken);
      chk("stream_taken", W'(taken), W'(1'b1));
    end
    idle(2, 1'b0);

    // Reset mid-operation with three entries queued
    for (int i = 0; i < 3; i++) offer(32'h5000 + 32'(i*4), 32'h6000, 1'b1, 2);
    log_base = obs_log.size();
    apply_reset();
    idle(3, 1'b0);
    chk("no_stale_writes", W'(obs_log.size()), W'(log_base));

    // Same-PC update against a full queue whose newest entry is 0x100->0x200
    obs_log.delete();
    offer(32'h700, 32'h710, 1'b1, 2);
    offer(32'h704, 32'h714, 1'b1, 2);
    offer(32'h708, 32'h718, 1'b1, 2);
    offer(32'h100, 32'h200, 1'b1, 2);
    step(1'b1, 32'h100, 32'h300, 1'b1, taken);
`ifdef BTB_UPDQ_COALESCE_EN
    chk("merge_full_taken", W'(taken), W'(1'b1));
    chk("merge_count",      W'(count), W'(DEPTH));
    idle(DEPTH + 2, 1'b0);
    chk("merge_new_once", W'(log_count({32'h100, 32'h300})), W'(1));
    chk("merge_old_gone", W'(log_count({32'h100, 32'h200})), W'(0));
`else
    chk("full_refused", W'(taken), W'(1'b0));
    offer(32'h100, 32'h300, 1'b0, 3);
    idle(DEPTH + 2, 1'b0);
    chk("dup_new_once", W'(log_count({32'h100, 32'h300})), W'(1));
    chk("dup_old_once", W'(log_count({32'h100, 32'h200})), W'(1));
    chk("dup_order",    obs_log[obs_log.size()-1], {32'h100, 32'h300});
`endif

    // Random traffic: small PC set so same-PC updates are frequent
    pend = 1'b0;
    rs = '0;
    rd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend || $urandom_range(0, 9) == 0) begin
        pend = ($urandom_range(0, 3) != 0);
        rs   = 32'h1000 + 32'($urandom_range(0, 3) * 4);
        rd   = $urandom;
      end
      h = ($urandom_range(0, 99) < ((i < 200) ? 60 : 20));
      step(pend, rs, rd, h, taken);
      if (taken) pend = 1'b0;
    end
    idle(DEPTH + 2, 1'b0);
    chk("final_empty", W'(count), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_btb_update_queue

// File: doc/btb_update_queue.md
# btb_update_queue

Buffers resolved taken-branch updates from the execute/retire side and drains them, one per cycle, into the branch target buffer's single write port. It sits directly upstream of the BTB: its outputs drive the BTB's write_enable/write_source_pc/write_dest_pc. It decouples bursty branch resolution from the BTB's one-write-per-cycle limit, with valid/ready back-pressure to the producer.

## Interface
- DEPTH, default 4: number of queued updates; power of two, at least 2.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; queue cleared while low.
- in_valid  in  1  producer presents a resolved taken branch.
- in_ready  out  1  queue accepts the update this cycle.
- in_source_pc  in  `XLEN  branch PC.
- in_dest_pc  in  `XLEN  resolved target PC.
- hold  in  1  suppress draining this cycle (BTB busy or being reset).
- btb_write_enable  out  1  head entry presented to BTB.
- btb_write_source_pc  out  `XLEN  head entry source PC.
- btb_write_dest_pc  out  `XLEN  head entry target PC.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Circular buffer of DEPTH entries; head pointer, tail pointer, and count registers. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Enqueue: when in_valid && in_ready, write {in_source_pc, in_dest_pc} at the tail, advance the tail, and increment count.
- in_ready = (count != DEPTH), from registered count only. There is no same-cycle pass-through when full.
- Dequeue: when btb_write_enable is high, the head is consumed at that edge. The BTB always accepts, so there is no ready from the BTB side.
- btb_write_enable = (count != 0) && !hold.
  - btb_write_source_pc and btb_write_dest_pc always show the head entry, even when enable is low.
  - Both are 0 when empty.
- Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance.
- hold high: no dequeue; enqueue is still allowed while not full.
- PCs pass through unmodified; no alignment or masking.
- Producer contract:
  - in_source_pc and in_dest_pc stay stable while in_valid && !in_ready.
  - A dropped in_valid without acceptance is legal; nothing is recorded.
- Reset low at any time:
  - count, head and tail go to 0 asynchronously, and all pending updates are discarded.
  - btb_write_enable=0, in_ready=0 while reset is low. in_ready goes to 1 on the first cycle after release.

## Timing
- Reset values: btb_write_enable=0, btb_write_source_pc=0, btb_write_dest_pc=0, count=0, in_ready=0 (1 once released).
- Latency: an update accepted at edge N is presented to the BTB in the cycle after edge N (earliest BTB write at edge N+1) if the queue was empty and hold is low.
- Throughput: one enqueue and one dequeue per cycle sustained; FIFO order is strictly preserved.
- Full: in_ready falls in the cycle after the DEPTH-th accepted enqueue and rises in the cycle after a dequeue.
- Outputs are combinational from registered state plus hold. There is no path from in_valid to any output.

## Configuration
- BTB_UPDQ_COALESCE_EN defined:
  - Applies when in_valid, count != 0, and the newest entry (tail-1) has source_pc == in_source_pc.
  - That entry's dest_pc is overwritten with in_dest_pc; no new slot is used and count is unchanged.
  - The update is accepted even when full: in_ready = (count != DEPTH) || match.
  - Exception: if the newest entry is also the head being dequeued this cycle (count==1 && btb_write_enable), enqueue normally instead.
- Not defined: no comparator; every accepted update takes a slot, and in_ready = (count != DEPTH).

## Structure
- Add to sys_defs.svh: typedef struct packed {logic [`XLEN-1:0] source_pc; logic [`XLEN-1:0] dest_pc;} BTB_UPDATE.
- Add `define BTB_UPDQ_DEPTH 4 as the default for DEPTH.
- Storage, pointers and count live in this module. The coalesce match logic stays inline under the macro; no sub-module is required.

## Test plan
- Reset:
  - Stimulus: hold reset low mid-operation with 3 entries queued, then release.
  - Required: count=0, btb_write_enable=0 immediately; in_ready=1 the cycle after release; no stale writes ever appear.
- Single update:
  - Stimulus: enqueue {0x100, 0x200} with the queue empty and hold=0.
  - Required: next cycle btb_write_enable=1, source=0x100, dest=0x200, count=1; the following cycle count=0 and enable=0.
- Fill and back-pressure:
  - Stimulus: hold=1 and enqueue 4 distinct updates, then offer a fifth.
  - Required: in_ready=0 and the fifth is not taken. Release hold: the 4 updates are written in order, and the fifth is accepted the cycle after the first dequeue.
- Simultaneous events and wrap-around:
  - Stimulus: continuous in_valid for 10 cycles with hold=0.
  - Required: count stays at 1 in steady state, pointers wrap, and all 10 updates are written in order.
- Coalesce with macro defined, full queue:
  - Stimulus: enqueue {0x100, 0x300} when the tail entry is {0x100, 0x200}.
  - Required: in_ready=1, count unchanged, and the BTB later receives 0x100->0x300 exactly once.
- Same stimulus with the macro undefined:
  - Required: in_ready=0 until space frees; both updates are then written in order.
